// File: rtl/motor_ctrl_pkg.sv
// Shared widths, the pipeline stage record and rounding/saturation constants
// for the motor-control datapath blocks.
package motor_ctrl_pkg;

  localparam int unsigned IPARK_D_WIDTH = 16;
  localparam int unsigned IPARK_Q_BITS  = 14;
  localparam int unsigned IPARK_TAG_W   = 4;

  // Output-stage record; data holds {alpha, beta}.
  typedef struct packed {
    logic                       valid;
    logic [IPARK_TAG_W-1:0]     tag;
    logic [2*IPARK_D_WIDTH-1:0] data;
  } ipark_stage_t;

  function automatic longint round_bias(input int unsigned shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/inverse_park_pipe_round_sat.sv
// Round-half-up, arithmetic shift and narrow; clamps to the output range
// when INVERSE_PARK_PIPE_SAT_EN is defined, otherwise wraps.
module round_sat
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] BIAS = IN_W'(round_bias(SHIFT));
`ifdef INVERSE_PARK_PIPE_SAT_EN
  localparam logic signed [IN_W-1:0] HI = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(sat_min(OUT_W));
`endif

  logic signed [IN_W-1:0] rnd;

  always_comb begin
    rnd = (x + BIAS) >>> SHIFT;
    y   = OUT_W'(rnd);
    sat = 1'b0;
`ifdef INVERSE_PARK_PIPE_SAT_EN
    if (rnd > HI) begin
      y   = OUT_W'(HI);
      sat = 1'b1;
    end else if (rnd < LO) begin
      y   = OUT_W'(LO);
      sat = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/inverse_park_pipe.sv
// Three-stage inverse Park transform (D/Q -> alpha/beta) with valid/ready flow
// control; optional output clamping via INVERSE_PARK_PIPE_SAT_EN.
module inverse_park_pipe
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned D_WIDTH = IPARK_D_WIDTH,
  parameter int unsigned Q_BITS  = IPARK_Q_BITS,
  parameter int unsigned TAG_W   = IPARK_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [D_WIDTH-1:0] D,
  input  logic signed [D_WIDTH-1:0] Q,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [D_WIDTH-1:0] alpha,
  output logic signed [D_WIDTH-1:0] beta,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat
);

  localparam int unsigned PW = 2 * D_WIDTH;
  localparam int unsigned SW = PW + 1;

  logic                      adv;
  logic                      s1_valid;
  logic [TAG_W-1:0]          s1_tag;
  logic signed [D_WIDTH-1:0] s1_d, s1_q, s1_sin, s1_cos;
  logic                      s2_valid;
  logic [TAG_W-1:0]          s2_tag;
  logic signed [PW-1:0]      p_dc, p_qs, p_ds, p_qc;
  logic signed [SW-1:0]      sum_a, sum_b;
  logic signed [D_WIDTH-1:0] nar_a, nar_b;
  logic                      sat_a, sat_b;
  ipark_stage_t              s3;
  logic                      s3_sat;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = !s3.valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    sum_a = SW'(p_dc) - SW'(p_qs);
    sum_b = SW'(p_ds) + SW'(p_qc);
  end

  round_sat #(.IN_W(SW), .OUT_W(D_WIDTH), .SHIFT(Q_BITS)) u_rs_alpha (
    .x(sum_a), .y(nar_a), .sat(sat_a)
  );

  round_sat #(.IN_W(SW), .OUT_W(D_WIDTH), .SHIFT(Q_BITS)) u_rs_beta (
    .x(sum_b), .y(nar_b), .sat(sat_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3       <= '0;
      s3_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3.valid <= s2_valid;
      s3.tag   <= s2_tag;
      s3.data  <= {nar_a, nar_b};
      s3_sat   <= sat_a | sat_b;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_tag <= in_tag;
      s1_d   <= D;
      s1_q   <= Q;
      s1_sin <= sin;
      s1_cos <= cos;
      s2_tag <= s1_tag;
      p_dc   <= PW'(s1_d) * PW'(s1_cos);
      p_qs   <= PW'(s1_q) * PW'(s1_sin);
      p_ds   <= PW'(s1_d) * PW'(s1_sin);
      p_qc   <= PW'(s1_q) * PW'(s1_cos);
    end
  end

  assign alpha     = s3.data[2*D_WIDTH-1 -: D_WIDTH];
  assign beta      = s3.data[D_WIDTH-1:0];
  assign out_tag   = s3.tag;
  assign out_valid = s3.valid;
  assign sat       = s3_sat;

endmodule

// File: doc/inverse_park_pipe.md
INVERSE_PARK_PIPE -- requirements
Module: inverse_park_pipe

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, signed sample width of D/Q/sin/cos/alpha/beta.
REQ-002 SHALL have parameter Q_BITS, default 14, fractional bits of sin/cos (1.0 = 2^Q_BITS).
REQ-003 SHALL have parameter TAG_W, default 4, width of the per-sample channel tag passed through.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports D, Q  in  D_WIDTH  signed rotating-frame inputs.
REQ-008 SHALL have ports sin, cos  in  D_WIDTH  signed Q_BITS-fraction angle terms.
REQ-009 SHALL have port in_tag  in  TAG_W  channel id, unsigned.
REQ-010 SHALL have port in_valid  in  1  input sample valid.
REQ-011 SHALL have port in_ready  out  1  block accepts a sample this cycle.
REQ-012 SHALL have ports alpha, beta  out  D_WIDTH  signed stationary-frame results.
REQ-013 SHALL have port out_tag  out  TAG_W  tag of the sample on alpha/beta.
REQ-014 SHALL have port out_valid  out  1  alpha/beta/out_tag valid.
REQ-015 SHALL have port out_ready  in  1  downstream accepts the output.
REQ-016 SHALL have port sat  out  1  alpha or beta of the current output was clamped.

Function
REQ-017 SHALL compute alpha = round((D*cos - Q*sin) / 2^Q_BITS) and beta = round((D*sin + Q*cos) / 2^Q_BITS).
REQ-018 SHALL form products at 2*D_WIDTH and sums at 2*D_WIDTH+1 bits, with no intermediate overflow.
REQ-019 SHALL round by adding 2^(Q_BITS-1) to each sum, then arithmetic right shift by Q_BITS (round half toward +inf).
REQ-020 SHALL be a 3-stage pipeline: S1 input register, S2 four product registers, S3 sum/round/narrow output register.
REQ-021 SHALL carry a valid bit and tag through every stage alongside the data.
REQ-022 SHALL present a sample at the output 3 cycles after its acceptance when out_ready is held high.
REQ-023 SHALL accept a sample only on a cycle where in_valid and in_ready are both high.
REQ-024 SHALL define an advance enable as (!out_valid || out_ready), and drive in_ready equal to it.
REQ-025 SHALL shift all stages together on advance enable, so empty stages propagate as bubbles.
REQ-026 SHALL freeze every stage on a cycle without advance enable; alpha, beta, out_tag, sat and out_valid then remain stable.
REQ-027 SHALL sustain one sample per cycle while out_ready is high.
REQ-028 SHALL never drop, duplicate or reorder samples under any in_valid/out_ready pattern.
REQ-029 SHALL let an output be retired and a new input accepted on the same cycle.

Reset
REQ-030 SHALL, while rst is high at a clock edge, clear all stage valid bits, out_valid and sat to 0, and alpha, beta, out_tag to 0.
REQ-031 SHALL discard all in-flight samples on reset mid-operation, with in_ready = 1 on the first cycle after rst falls.

Configuration
REQ-032 SHALL, with macro INVERSE_PARK_PIPE_SAT_EN defined, clamp each rounded result to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1], and set sat with that output when either result clamped.
REQ-033 SHALL, without INVERSE_PARK_PIPE_SAT_EN, truncate results to the low D_WIDTH bits (two's-complement wrap) and tie sat to 0.

Structure
REQ-034 SHALL take shared rounding/saturation constants and an ipark_stage_t struct typedef {valid, tag, data} from package motor_ctrl_pkg.
REQ-035 SHALL implement the narrow/round/saturate step as sub-module round_sat, parameterised by input width, output width and shift.

Verification
REQ-036 SHALL cover: D_WIDTH=16, Q_BITS=14, D=1000, Q=0, cos=16384, sin=0, out_ready=1 -> alpha=1000, beta=0, out_valid exactly 3 cycles after accept.
REQ-037 SHALL cover: D=0, Q=1000, sin=16383, cos=0 -> alpha=-1000, beta=0.
REQ-038 SHALL cover: D=Q=32767, sin=cos=16384 -> alpha=0; beta=32767, sat=1 with the macro; beta=-2, sat=0 without it.
REQ-039 SHALL cover: 8 back-to-back samples with tags 0..7 and out_ready low for 5 cycles mid-stream -> in_ready low on those cycles, outputs held stable, all 8 emitted in tag order with none lost.
REQ-040 SHALL cover: rst for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, none of those 3 ever emitted, next accepted sample out after 3 cycles.
REQ-041 SHALL cover: random in_valid/out_ready for 10k samples against a reference model -> bit-exact results and 1 sample/cycle whenever both are held high.
